fetch_align: RTL and testbench
==============================

# fetch_align

Instruction fetch and align stage for the RV32/RVC core. It sits between instruction memory and decode, directly downstream of the PC register. It fetches word-aligned 32-bit lines, keeps a 3-halfword buffer, and emits one aligned instruction at a time (16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary) with its PC and a compressed flag. A redirect input restarts fetch at any halfword-aligned address.

## Interface
- XLEN, 32, datapath/address width
- RESET, 0, fetch start address after reset (halfword aligned)

- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- redirect  in  1  flush buffer, restart fetch at redirect_pc
- redirect_pc  in  XLEN  new instruction address; bit 0 ignored
- mem_req  out  1  fetch request valid
- mem_addr  out  XLEN  word-aligned fetch address, bits [1:0]=0
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid; earliest the cycle after mem_gnt
- mem_rdata  in  32  fetched word, little-endian halfwords
- inst_valid  out  1  inst/inst_pc/inst_rvc valid
- inst_ready  in  1  decode consumes the instruction this cycle
- inst  out  32  instruction; compressed: {16'b0, halfword}
- inst_pc  out  XLEN  address of inst
- inst_rvc  out  1  inst is 16-bit (low bits != 2'b11)

## Operation
- Registers: buf (3×16b), cnt (0..3 halfwords), dpc (decode PC), fpc (word fetch address), drop (discard low half of next word), stale (in-flight response is to be discarded), state.
- FSM: IDLE -> REQ when cnt<=1; REQ -> WAIT on mem_gnt; WAIT -> IDLE on mem_rvalid. mem_req = (state==REQ); mem_addr = fpc. At most one request outstanding.
- Request held with mem_addr stable until mem_gnt, including across redirect.
- On grant: fpc += 4.
- Response (mem_rvalid, stale=0): append {hi,lo} (cnt+=2), or only hi if drop (cnt+=1, clear drop). stale=1: discard data, clear stale.
- Output: hw0 = buf[0]; inst_rvc = hw0[1:0]!=2'b11; inst_valid = cnt>=1 && (inst_rvc || cnt>=2); inst = inst_rvc ? {16'b0,hw0} : {buf[1],hw0}; inst_pc = dpc.
- Consume (inst_valid && inst_ready): shift buffer by 1 or 2 halfwords, dpc += 2 or 4 (mod 2^XLEN).
- Same-cycle consume and append: shift first, then append behind the remaining entries; cnt = cnt - used + appended; never exceeds 3.
- Redirect (priority over everything): cnt<=0; dpc<=redirect_pc & ~1; fpc<=redirect_pc & ~3; drop<=redirect_pc[1]; stale<=1 if state is REQ or WAIT (including a response arriving the same cycle), else 0. Any consume that cycle is ignored; inst_valid is not suppressed combinationally.
- Address wrap: fpc and dpc wrap modulo 2^XLEN silently.

## Timing
- Reset values: state IDLE, mem_req 0, mem_addr RESET & ~3, cnt 0, inst_valid 0, inst 0, inst_rvc 0 (buf zero -> hw0[1:0]=00), inst_pc RESET, drop RESET[1], stale 0.
- mem_req rises at the first clock edge after reset release.
- Fetch latency: data on edge N (mem_rvalid) -> inst_valid high in the cycle after edge N.
- After redirect, the first valid instruction appears no earlier than 2 cycles after the next grant-to-response of a non-stale request.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); any pending response is ignored after release.
- inst_ready=0: all outputs stable; no request issued while cnt>=2.

## Test plan
- Reset, RESET=0x100: mem_req=1, mem_addr=0x100; grant, rdata 0x00000013 -> inst=0x00000013, inst_pc=0x100, inst_rvc=0, consumed, next mem_addr=0x104.
- Compressed pair: rdata 0x45014501 at 0x100 -> inst 0x00004501 at 0x100 then at 0x102, inst_rvc=1, one per cycle with inst_ready=1.
- Straddle: 0x100 -> 0x00134501, 0x104 -> 0x45010000 -> 0x4501@0x100, 0x00000013@0x102 (valid only after second word), 0x4501@0x106.
- Redirect to 0x202 while in WAIT: stale response 0xDEADBEEF discarded; next mem_addr=0x200; rdata 0x45010001 -> first inst 0x4501@0x202, low half dropped.
- Backpressure: inst_ready=0 for 10 cycles with cnt=3 -> outputs stable, mem_req=0; release -> drains correctly, request resumes when cnt<=1.
- Reset asserted while in REQ with mem_gnt pending -> mem_req=0, inst_valid=0 immediately; after release fetch restarts at RESET.

Source files
------------

// File: rtl/fetch_align.sv
// Fetch/align stage: word fetch into a 3-halfword buffer,
// emits one aligned RV32/RVC instruction per handshake.
module fetch_align #(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_rvc
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  localparam logic [XLEN-1:0] RST_W = RESET & ~XLEN'(3);

  state_e                state_q, state_d;
  logic [2:0][15:0]      buf_q, buf_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [XLEN-1:0]       dpc_q, dpc_d;
  logic [XLEN-1:0]       fpc_q, fpc_d;
  logic [XLEN-1:0]       areq_q, areq_d;
  logic                  drop_q, drop_d;
  logic                  stale_q, stale_d;

  logic [15:0]           hw0;
  logic                  rvc_raw;
  logic                  consume;
  logic                  grant;
  logic                  resp;
  logic                  take;
  logic [1:0]            used;
  logic [1:0]            rem;
  logic [1:0]            add;
  logic [2:0][15:0]      sb;

  assign hw0        = buf_q[0];
  assign rvc_raw    = hw0[1:0] != 2'b11;
  assign inst_valid = (cnt_q != 2'd0) && (rvc_raw || cnt_q >= 2'd2);
  assign inst_rvc   = (cnt_q != 2'd0) && rvc_raw;
  assign inst       = inst_rvc ? {16'b0, hw0} : {buf_q[1], hw0};
  assign inst_pc    = dpc_q;
  assign mem_req    = state_q == REQ;
  assign mem_addr   = areq_q;

  assign consume = inst_valid && inst_ready && !redirect;
  assign grant   = (state_q == REQ) && mem_gnt;
  assign resp    = (state_q == WAIT) && mem_rvalid;
  assign take    = resp && !stale_q && !redirect;
  assign used    = consume ? (inst_rvc ? 2'd1 : 2'd2) : 2'd0;
  assign rem     = cnt_q - used;
  assign add     = take ? (drop_q ? 2'd1 : 2'd2) : 2'd0;
  assign sb      = buf_q >> {used, 4'b0000};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cnt_q <= 2'd1) state_d = REQ;
      REQ:     if (mem_gnt) state_d = WAIT;
      WAIT:    if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_d   = sb;
    cnt_d   = rem + add;
    dpc_d   = dpc_q + XLEN'({used, 1'b0});
    fpc_d   = fpc_q;
    drop_d  = drop_q;
    stale_d = stale_q;
    if (take) begin
      // Append behind whatever survives this cycle's shift.
      case (rem)
        2'd0: begin
          if (drop_q) buf_d[0] = mem_rdata[31:16];
          else begin
            buf_d[0] = mem_rdata[15:0];
            buf_d[1] = mem_rdata[31:16];
          end
        end
        2'd1: begin
          if (drop_q) buf_d[1] = mem_rdata[31:16];
          else begin
            buf_d[1] = mem_rdata[15:0];
            buf_d[2] = mem_rdata[31:16];
          end
        end
        2'd2: buf_d[2] = mem_rdata[31:16];
        default: ;
      endcase
      drop_d = 1'b0;
    end
    if (resp && stale_q) stale_d = 1'b0;
    // A grant for a request already marked stale must not advance.
    if (grant && !stale_q) fpc_d = fpc_q + XLEN'(4);
    if (redirect) begin
      cnt_d   = 2'd0;
      dpc_d   = redirect_pc & ~XLEN'(1);
      fpc_d   = redirect_pc & ~XLEN'(3);
      drop_d  = redirect_pc[1];
      stale_d = state_q != IDLE;
    end
  end

  always_comb begin
    areq_d = areq_q;
    if (state_q == IDLE && state_d == REQ) areq_d = fpc_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= 2'd0;
      dpc_q   <= RESET;
      fpc_q   <= RST_W;
      areq_q  <= RST_W;
      drop_q  <= RESET[1];
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      dpc_q   <= dpc_d;
      fpc_q   <= fpc_d;
      areq_q  <= areq_d;
      drop_q  <= drop_d;
      stale_q <= stale_d;
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align: reset, RVC/RV32 mix,
// straddle, redirect, backpressure, wrap, mid-run reset.
module tb_fetch_align;

  logic        clock;
  logic        reset;
  logic        redirect;
  logic [31:0] rpc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        inst_valid;
  logic        ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_rvc;

  int n_cmp;
  int n_err;

  fetch_align #(
    .XLEN(32),
    .RESET(32'h100)
  ) dut (
    .clock(clock),
    .reset(reset),
    .redirect(redirect),
    .redirect_pc(rpc),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_gnt(gnt),
    .mem_rvalid(rvalid),
    .mem_rdata(rdata),
    .inst_valid(inst_valid),
    .inst_ready(ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_rvc(inst_rvc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wait_req(input logic [31:0] ea);
    for (int i = 0; i < 20 && !mem_req; i++) tick();
    chk("req_seen", {31'b0, mem_req}, 32'd1);
    chk("req_addr", mem_addr, ea);
  endtask

  task automatic fetch(input logic [31:0] ea, input logic [31:0] d);
    wait_req(ea);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    rvalid = 1'b1;
    rdata = d;
    tick();
    rvalid = 1'b0;
  endtask

  task automatic junk();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    rvalid = 1'b1;
    rdata = 32'hDEADBEEF;
    tick();
    rvalid = 1'b0;
    chk("stale_valid", {31'b0, inst_valid}, 32'd0);
  endtask

  task automatic take(input logic [31:0] ei, input logic [31:0] ep,
                      input logic er);
    chk("valid", {31'b0, inst_valid}, 32'd1);
    chk("inst", inst, ei);
    chk("pc", inst_pc, ep);
    chk("rvc", {31'b0, inst_rvc}, {31'b0, er});
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    redirect = 1'b0;
    rpc = '0;
    gnt = 1'b0;
    rvalid = 1'b0;
    rdata = '0;
    ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'h100);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_rvc", {31'b0, inst_rvc}, 32'd0);
    chk("rst_pc", inst_pc, 32'h100);
    reset = 1'b1;
    tick();
    chk("req_rise", {31'b0, mem_req}, 32'd1);

    fetch(32'h100, 32'h00000013);
    take(32'h00000013, 32'h100, 1'b0);

    fetch(32'h104, 32'h45014501);
    take(32'h00004501, 32'h104, 1'b1);
    take(32'h00004501, 32'h106, 1'b1);

    fetch(32'h108, 32'h00134501);
    take(32'h00004501, 32'h108, 1'b1);
    chk("strad_wait", {31'b0, inst_valid}, 32'd0);
    fetch(32'h10C, 32'h45010000);

    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'b0, inst_valid}, 32'd1);
      chk("bp_inst", inst, 32'h00000013);
      chk("bp_pc", inst_pc, 32'h10A);
      chk("bp_req", {31'b0, mem_req}, 32'd0);
      tick();
    end
    take(32'h00000013, 32'h10A, 1'b0);
    take(32'h00004501, 32'h10E, 1'b1);
    chk("resume_req", {31'b0, mem_req}, 32'd1);
    chk("resume_addr", mem_addr, 32'h110);

    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    redirect = 1'b1;
    rpc = 32'h202;
    tick();
    redirect = 1'b0;
    rvalid = 1'b1;
    rdata = 32'hDEADBEEF;
    tick();
    rvalid = 1'b0;
    chk("wait_stale", {31'b0, inst_valid}, 32'd0);
    fetch(32'h200, 32'h45010001);
    take(32'h00004501, 32'h202, 1'b1);

    chk("rq_req", {31'b0, mem_req}, 32'd1);
    chk("rq_addr", mem_addr, 32'h204);
    redirect = 1'b1;
    rpc = 32'h300;
    tick();
    redirect = 1'b0;
    chk("hold_req", {31'b0, mem_req}, 32'd1);
    chk("hold_addr", mem_addr, 32'h204);
    junk();
    fetch(32'h300, 32'h00000013);
    take(32'h00000013, 32'h300, 1'b0);

    wait_req(32'h304);
    redirect = 1'b1;
    rpc = 32'hFFFFFFFE;
    tick();
    redirect = 1'b0;
    junk();
    fetch(32'hFFFFFFFC, 32'h45010000);
    take(32'h00004501, 32'hFFFFFFFE, 1'b1);
    chk("wrap_req", {31'b0, mem_req}, 32'd1);
    chk("wrap_addr", mem_addr, 32'h0);
    chk("wrap_pc", inst_pc, 32'h0);

    gnt = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_req", {31'b0, mem_req}, 32'd0);
    chk("mid_valid", {31'b0, inst_valid}, 32'd0);
    chk("mid_addr", mem_addr, 32'h100);
    chk("mid_pc", inst_pc, 32'h100);
    gnt = 1'b0;
    rvalid = 1'b1;
    rdata = 32'h45014501;
    @(negedge clock);
    reset = 1'b1;
    tick();
    rvalid = 1'b0;
    chk("post_valid", {31'b0, inst_valid}, 32'd0);
    fetch(32'h100, 32'h00000013);
    take(32'h00000013, 32'h100, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
